// File: rtl/cdda_sample_fifo_if.sv
// cdda_sample_fifo_if: DMA byte snoop and serializer sample handshake.
// master drives bytes and requests; slave returns the sample.
interface cdda_sample_fifo_if;
   logic [7:0]  dma_data;
   logic [8:0]  dma_addr;
   logic        dma_strobe;
   logic        sample_req;
   logic [31:0] sample_out;

   modport master (
      output dma_data,
      output dma_addr,
      output dma_strobe,
      output sample_req,
      input  sample_out
   );

   modport slave (
      input  dma_data,
      input  dma_addr,
      input  dma_strobe,
      input  sample_req,
      output sample_out
   );
endinterface

// File: rtl/cdda_sample_fifo.sv
// cdda_sample_fifo: packs SD DMA bytes into stereo samples, buffers
// them and feeds the CDDA serializer behind a prime threshold.
module cdda_sample_fifo #(
   parameter int DEPTH_LOG2  = 8,
   parameter int PRIME_LEVEL = 128
) (
   input  logic                  clk,
   input  logic                  reset_,
   input  logic                  enable,
   input  logic                  capture_en,
   input  logic                  flush,
   input  logic                  clear_flags,
   cdda_sample_fifo_if.slave     bus,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  playing,
   output logic                  low_water,
   output logic                  overflow,
   output logic                  underrun,
   output logic                  sync_err
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int LW    = DEPTH_LOG2 + 1;

   localparam logic [LW-1:0] L_FULL  = LW'(DEPTH);
   localparam logic [LW-1:0] L_HALF  = LW'(DEPTH / 2);
   localparam logic [LW-1:0] L_PRIME = LW'(PRIME_LEVEL);
   localparam logic [LW-1:0] L_ONE   = LW'(1);
   localparam logic [DEPTH_LOG2-1:0] P_ONE = DEPTH_LOG2'(1);

   typedef enum logic [1:0] {
      ST_STOPPED,
      ST_PRIMING,
      ST_PLAYING
   } state_t;

   state_t                r_state;
   logic                  r_playing;
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [LW-1:0]         r_level;
   logic                  r_low;
   logic [23:0]           r_partial;
   logic [1:0]            r_exp;
   logic                  r_push_vld;
   logic [31:0]           r_push_word;
   logic [31:0]           r_sample;
   logic [31:0]           r_rd_q;
   logic                  r_ovf;
   logic                  r_und;
   logic                  r_sync;
   logic [31:0]           r_mem [DEPTH];

   logic [1:0]            w_lane;
   logic                  w_cap;
   logic                  w_in_seq;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_req_play;
   logic                  w_pop;
   logic                  w_starve;
   logic                  w_push;
   logic                  w_drop;
   logic [DEPTH_LOG2-1:0] w_rd_ptr_nxt;
   logic [DEPTH_LOG2-1:0] w_wr_ptr_nxt;
   logic [LW-1:0]         w_level_nxt;
   logic                  w_unused_addr;

   assign w_unused_addr = &{1'b0, bus.dma_addr[8:2]};

   assign w_lane     = bus.dma_addr[1:0];
   assign w_cap      = bus.dma_strobe & capture_en & ~flush;
   assign w_in_seq   = (w_lane == r_exp);
   assign w_full     = (r_level == L_FULL);
   assign w_empty    = (r_level == '0);
   assign w_req_play = bus.sample_req & ~flush
                     & (r_state == ST_PLAYING);
   assign w_pop      = w_req_play & ~w_empty;
   assign w_starve   = w_req_play & w_empty;
   assign w_push     = r_push_vld & ~flush & ~w_full;
   assign w_drop     = r_push_vld & ~flush & w_full;

   // next pointers and fill count; flush returns everything to zero
   always_comb begin
      w_rd_ptr_nxt = r_rd_ptr;
      w_wr_ptr_nxt = r_wr_ptr;
      w_level_nxt  = r_level;
      if (flush) begin
         w_rd_ptr_nxt = '0;
         w_wr_ptr_nxt = '0;
         w_level_nxt  = '0;
      end else begin
         if (w_pop)
            w_rd_ptr_nxt = r_rd_ptr + P_ONE;
         if (w_push)
            w_wr_ptr_nxt = r_wr_ptr + P_ONE;
         if (w_push & ~w_pop)
            w_level_nxt = r_level + L_ONE;
         else if (w_pop & ~w_push)
            w_level_nxt = r_level - L_ONE;
      end
   end

   // byte-lane packer; a completed word is pushed the following cycle
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         r_partial   <= '0;
         r_exp       <= '0;
         r_push_vld  <= 1'b0;
         r_push_word <= '0;
      end else if (flush) begin
         r_partial  <= '0;
         r_exp      <= '0;
         r_push_vld <= 1'b0;
      end else begin
         r_push_vld <= 1'b0;
         if (w_cap) begin
            if (w_in_seq) begin
               r_exp <= w_lane + 2'd1;
               unique case (w_lane)
                  2'd0: r_partial[7:0]   <= bus.dma_data;
                  2'd1: r_partial[15:8]  <= bus.dma_data;
                  2'd2: r_partial[23:16] <= bus.dma_data;
                  2'd3: begin
                     r_push_vld  <= 1'b1;
                     r_push_word <= {bus.dma_data, r_partial};
                  end
               endcase
            end else begin
               // a stray lane-0 byte starts the next word straight away
               r_partial <= {16'h0000,
                  (w_lane == 2'd0) ? bus.dma_data : 8'h00};
               r_exp     <= (w_lane == 2'd0) ? 2'd1 : 2'd0;
            end
         end
      end
   end

   // FIFO pointers, fill count and low-water indication
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_low    <= 1'b0;
      end else begin
         r_wr_ptr <= w_wr_ptr_nxt;
         r_rd_ptr <= w_rd_ptr_nxt;
         r_level  <= w_level_nxt;
         r_low    <= (w_level_nxt < L_HALF);
      end
   end

   // sample RAM write port
   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= r_push_word;
   end

   // registered read of the next head, write-first on an address hit,
   // so the head word is already waiting when a request arrives
   always_ff @(posedge clk) begin
      if (w_push && (r_wr_ptr == w_rd_ptr_nxt))
         r_rd_q <= r_push_word;
      else
         r_rd_q <= r_mem[w_rd_ptr_nxt];
   end

   // serializer output: head word on a pop, silence on any other request
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_)
         r_sample <= '0;
      else if (flush)
         r_sample <= '0;
      else if (w_pop)
         r_sample <= r_rd_q;
      else if (bus.sample_req)
         r_sample <= '0;
   end

   // playback state machine with registered playing indication
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         r_state   <= ST_STOPPED;
         r_playing <= 1'b0;
      end else if (!enable) begin
         r_state   <= ST_STOPPED;
         r_playing <= 1'b0;
      end else begin
         unique case (r_state)
            ST_STOPPED: begin
               r_state   <= ST_PRIMING;
               r_playing <= 1'b0;
            end
            ST_PRIMING: begin
               if (!flush && (r_level >= L_PRIME)) begin
                  r_state   <= ST_PLAYING;
                  r_playing <= 1'b1;
               end
            end
            ST_PLAYING: begin
               if (flush || w_starve) begin
                  r_state   <= ST_PRIMING;
                  r_playing <= 1'b0;
               end
            end
            default: begin
               r_state   <= ST_STOPPED;
               r_playing <= 1'b0;
            end
         endcase
      end
   end

   // sticky error flags; a new event beats a simultaneous clear
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         r_ovf  <= 1'b0;
         r_und  <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         if (clear_flags) begin
            r_ovf  <= 1'b0;
            r_und  <= 1'b0;
            r_sync <= 1'b0;
         end
         if (w_drop)
            r_ovf <= 1'b1;
         if (w_starve)
            r_und <= 1'b1;
         if (w_cap && !w_in_seq)
            r_sync <= 1'b1;
      end
   end

   assign bus.sample_out = r_sample;
   assign level          = r_level;
   assign playing        = r_playing;
   assign low_water      = r_low;
   assign overflow       = r_ovf;
   assign underrun       = r_und;
   assign sync_err       = r_sync;

endmodule

// File: tb/tb_cdda_sample_fifo.sv
// tb_cdda_sample_fifo: random and directed stimulus against a
// queue-based reference model with a decoupled sample scoreboard.
module tb_cdda_sample_fifo;

   localparam int DL    = 8;
   localparam int DEPTH = 256;
   localparam int PRIME = 128;

   logic          clk = 1'b0;
   logic          reset_ = 1'b0;
   logic          enable = 1'b0;
   logic          capture_en = 1'b0;
   logic          flush = 1'b0;
   logic          clear_flags = 1'b0;
   logic [DL:0]   level;
   logic          playing;
   logic          low_water;
   logic          overflow;
   logic          underrun;
   logic          sync_err;

   cdda_sample_fifo_if bus();

   cdda_sample_fifo #(
      .DEPTH_LOG2  (DL),
      .PRIME_LEVEL (PRIME)
   ) dut (
      .clk         (clk),
      .reset_      (reset_),
      .enable      (enable),
      .capture_en  (capture_en),
      .flush       (flush),
      .clear_flags (clear_flags),
      .bus         (bus),
      .level       (level),
      .playing     (playing),
      .low_water   (low_water),
      .overflow    (overflow),
      .underrun    (underrun),
      .sync_err    (sync_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // reference model: sample queue, pending word, lane tracker, state
   typedef enum int {M_STOP, M_PRIME, M_PLAY} mst_t;
   logic [31:0] mq[$];
   logic [31:0] exp_q[$];
   bit          m_pend;
   logic [31:0] m_pend_w;
   logic [7:0]  m_byte [4];
   int          m_exp;
   mst_t        m_st;
   bit          m_ovf, m_und, m_sync;
   bit          chk_en = 1'b0;

   logic [8:0]  baddr = '0;
   bit          prev_req = 1'b0;
   bit          t_en = 1'b0;
   bit          t_cap = 1'b0;

   task automatic model_reset();
      mq.delete();
      exp_q.delete();
      m_pend = 0;
      m_exp  = 0;
      m_st   = M_STOP;
      m_ovf  = 0;
      m_und  = 0;
      m_sync = 0;
   endtask

   task automatic model_step();
      int lvl;
      int lane;
      bit starve;
      lvl = mq.size();
      starve = 0;
      if (clear_flags) begin
         m_ovf = 0; m_und = 0; m_sync = 0;
      end
      if (bus.sample_req) begin
         if (!flush && m_st == M_PLAY && lvl > 0)
            exp_q.push_back(mq[0]);
         else
            exp_q.push_back(32'h0);
      end
      if (flush) begin
         mq.delete();
         m_pend = 0;
         m_exp  = 0;
      end else begin
         if (bus.sample_req && m_st == M_PLAY) begin
            if (lvl > 0) void'(mq.pop_front());
            else begin starve = 1; m_und = 1; end
         end
         if (m_pend) begin
            if (lvl == DEPTH) m_ovf = 1;
            else mq.push_back(m_pend_w);
         end
         m_pend = 0;
         if (bus.dma_strobe && capture_en) begin
            lane = int'(bus.dma_addr[1:0]);
            if (lane == m_exp) begin
               m_byte[lane] = bus.dma_data;
               m_exp = (lane + 1) % 4;
               if (lane == 3) begin
                  m_pend = 1;
                  m_pend_w = {m_byte[3], m_byte[2], m_byte[1], m_byte[0]};
               end
            end else begin
               m_sync = 1;
               m_byte[0] = bus.dma_data;
               m_exp = (lane == 0) ? 1 : 0;
            end
         end
      end
      if (!enable) m_st = M_STOP;
      else begin
         case (m_st)
            M_STOP:  m_st = M_PRIME;
            M_PRIME: if (!flush && lvl >= PRIME) m_st = M_PLAY;
            M_PLAY:  if (flush || starve) m_st = M_PRIME;
            default: m_st = M_STOP;
         endcase
      end
   endtask

   // one clock of stimulus, applied at the falling edge
   task automatic cyc(bit st, logic [8:0] a, logic [7:0] d,
                      bit rq, bit fl, bit cl);
      @(negedge clk);
      enable         = t_en;
      capture_en     = t_cap;
      bus.dma_strobe = st;
      bus.dma_addr   = a;
      bus.dma_data   = d;
      bus.sample_req = rq;
      flush          = fl;
      clear_flags    = cl;
      prev_req       = rq;
      model_step();
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) cyc(0, baddr, 8'h00, 0, 0, 0);
   endtask

   task automatic feed_word(logic [31:0] w, bit rq);
      for (int b = 0; b < 4; b++) begin
         cyc(1, baddr, w[8*b +: 8], rq && (b == 1), 0, 0);
         baddr = baddr + 9'd1;
      end
   endtask

   task automatic rnd_phase(int n, int p_byte, int p_req, int p_skip,
                            int p_fl);
      for (int i = 0; i < n; i++) begin
         bit         st, rq, fl, cl;
         logic [8:0] a;
         st = ($urandom_range(99) < p_byte);
         a  = baddr;
         if (st) begin
            if ($urandom_range(99) < p_skip)
               a = baddr + 9'd1 + 9'($urandom_range(2));
            baddr = a + 9'd1;
         end
         rq = !prev_req && ($urandom_range(99) < p_req);
         fl = ($urandom_range(999) < p_fl);
         cl = ($urandom_range(99) < 3);
         t_cap = ($urandom_range(99) < 95);
         cyc(st, a, 8'($urandom), rq, fl, cl);
      end
      t_cap = 1;
   endtask

   task automatic check_zero_outputs(string tag);
      chk({tag, "_level"},     level, 0);
      chk({tag, "_playing"},   playing, 0);
      chk({tag, "_low_water"}, low_water, 0);
      chk({tag, "_overflow"},  overflow, 0);
      chk({tag, "_underrun"},  underrun, 0);
      chk({tag, "_sync_err"},  sync_err, 0);
      chk({tag, "_sample"},    bus.sample_out, 0);
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset_ = 1'b1;
      model_reset();
      model_step();
      chk_en = 1'b1;
   endtask

   // monitor: scoreboard pops on each request and status tracking
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (chk_en) begin
            if (bus.sample_req) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL scoreboard: request with no expectation");
               end else
                  chk("sample_out", bus.sample_out, exp_q.pop_front());
            end
            chk("level",     level, mq.size());
            chk("playing",   playing, m_st == M_PLAY);
            chk("low_water", low_water, mq.size() < DEPTH / 2);
            chk("overflow",  overflow, m_ovf);
            chk("underrun",  underrun, m_und);
            chk("sync_err",  sync_err, m_sync);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] w;
      bus.dma_strobe = 0;
      bus.dma_addr   = '0;
      bus.dma_data   = '0;
      bus.sample_req = 0;
      #3;
      check_zero_outputs("reset");
      repeat (2) @(negedge clk);
      t_en  = 1;
      t_cap = 1;
      enable = 1;
      capture_en = 1;
      release_reset();

      // 127 words while priming, requests answered with silence
      feed_word(32'h44332211, 1);
      for (int k = 1; k < PRIME - 1; k++) feed_word($urandom, 1);
      idle(2);
      chk("prime_level", level, PRIME - 1);
      chk("prime_playing", playing, 0);
      chk("prime_underrun", underrun, 0);
      feed_word($urandom, 0);
      idle(3);
      chk("prime_done_playing", playing, 1);
      cyc(0, baddr, 8'h00, 1, 0, 0);
      idle(1);
      chk("first_sample", bus.sample_out, 32'h44332211);
      chk("first_pop_level", level, PRIME - 1);

      // lane discontinuity then a clean word
      cyc(1, 9'd0, 8'hA0, 0, 0, 0);
      cyc(1, 9'd1, 8'hA1, 0, 0, 0);
      cyc(1, 9'd3, 8'hA3, 0, 0, 0);
      for (int b = 4; b < 8; b++) cyc(1, 9'(b), 8'(8'hB0 + b), 0, 0, 0);
      baddr = 9'd8;
      idle(2);
      chk("sync_err_set", sync_err, 1);
      chk("sync_level", level, PRIME);
      cyc(0, baddr, 8'h00, 0, 0, 1);
      idle(1);
      chk("sync_cleared", sync_err, 0);

      rnd_phase(3000, 60, 30, 2, 2);
      rnd_phase(3000, 90, 10, 1, 1);

      // overflow with playback disabled, then drain to underrun
      t_en = 0;
      cyc(0, baddr, 8'h00, 0, 1, 1);
      baddr = '0;
      for (int k = 0; k < DEPTH + 1; k++) feed_word($urandom, 0);
      idle(2);
      chk("ovf_level", level, DEPTH);
      chk("ovf_flag", overflow, 1);
      t_en = 1;
      for (int i = 0; i < 600; i++) cyc(0, baddr, 8'h00, (i % 2) == 0, 0, 0);
      idle(1);
      chk("drain_underrun", underrun, 1);
      chk("drain_playing", playing, 0);
      chk("drain_level", level, 0);
      cyc(0, baddr, 8'h00, 0, 0, 1);
      idle(1);
      chk("clear_underrun", underrun, 0);
      chk("clear_overflow", overflow, 0);

      // flush colliding with a push and a request
      baddr = '0;
      for (int k = 0; k < PRIME + 2; k++) feed_word($urandom, 0);
      idle(3);
      chk("pre_flush_playing", playing, 1);
      w = 32'hDEADBEEF;
      feed_word(w, 0);
      cyc(0, baddr, 8'h00, 1, 1, 0);
      cyc(1, 9'd1, 8'h55, 0, 0, 0);
      idle(1);
      chk("flush_level", level, 0);
      chk("flush_sample", bus.sample_out, 0);
      chk("flush_sync_err", sync_err, 1);
      chk("flush_playing", playing, 0);

      // asynchronous reset while playing with a partial word held
      cyc(0, baddr, 8'h00, 0, 0, 1);
      baddr = '0;
      for (int k = 0; k < PRIME + 2; k++) feed_word($urandom, 0);
      idle(3);
      cyc(0, baddr, 8'h00, 1, 0, 0);
      cyc(1, 9'd0, 8'h12, 0, 0, 0);
      cyc(1, 9'd1, 8'h34, 0, 0, 0);
      idle(1);
      chk("pre_reset_playing", playing, 1);
      @(negedge clk);
      chk_en = 0;
      bus.dma_strobe = 0;
      bus.sample_req = 0;
      #2;
      reset_ = 1'b0;
      #1;
      check_zero_outputs("async_reset");
      @(negedge clk);
      baddr = '0;
      release_reset();
      rnd_phase(1500, 70, 25, 2, 2);
      idle(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
